// File: rtl/collision_detector.sv
// collision_detector
//   Moves the snake head one cell per accepted move request and classifies
//   the landing cell as empty, apple (goodColl) or fatal (badColl: border or
//   own body). Keeps a head-position history (hist[0] is the head) and a
//   length counter. The body is compared against the next cell one segment
//   per cycle.
//
// Ports
//   clk         rising-edge clock
//   nRst        synchronous active-low reset
//   moveStrobe  one-cycle move request, taken only while busy is low
//   dir         requested direction: 0=+x, 1=-x, 2=-y, 3=+y
//   restart     synchronous restart, same effect as nRst low
//   appleX/Y    apple cell, looked at only when a move commits
//   goodColl    one-cycle pulse: head landed on the apple
//   badColl     one-cycle pulse: border or self collision
//   isDead      high from the first badColl until reset/restart
//   busy        high while a move is in flight
//   headX/Y     committed head cell
//   snakeLen    current length
//   dbg_state   current FSM state (debug visibility only)
//
// Handshake: moveStrobe is a one-cycle valid with no ready/backpressure.
// It is accepted only when the FSM is IDLE (busy low, which includes the
// cycle busy falls). Strobes seen while busy or dead are dropped, never
// queued.
module collision_detector #(
    parameter int GRID_X   = 16,
    parameter int GRID_Y   = 12,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 4,
    parameter int START_Y  = 6,
    localparam int XW = $clog2(GRID_X),
    localparam int YW = $clog2(GRID_Y),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          moveStrobe,
    input  logic [1:0]    dir,
    input  logic          restart,
    input  logic [XW-1:0] appleX,
    input  logic [YW-1:0] appleY,
    output logic          goodColl,
    output logic          badColl,
    output logic          isDead,
    output logic          busy,
    output logic [XW-1:0] headX,
    output logic [YW-1:0] headY,
    output logic [LW-1:0] snakeLen,
    output logic [2:0]    dbg_state
);

    localparam int IW = $clog2(MAX_LEN);
    localparam logic [XW:0] X_ONE = 1;
    localparam logic [YW:0] Y_ONE = 1;
    localparam logic [XW:0] X_MAX = (XW + 1)'(GRID_X - 1);
    localparam logic [YW:0] Y_MAX = (YW + 1)'(GRID_Y - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SCAN   = 3'd2,
        S_COMMIT = 3'd3,
        S_DEAD   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [XW-1:0] hist_x [MAX_LEN];
    logic [YW-1:0] hist_y [MAX_LEN];

    // Next cell carries one extra bit so that stepping off either edge
    // (including below zero) shows up as a value above the grid maximum.
    logic [XW:0]   nxt_x;
    logic [YW:0]   nxt_y;
    logic [1:0]    cur_dir;
    logic [IW-1:0] scan_ptr;   // segment compared this cycle (index-1)
    logic          hit_q;
    logic [LW-1:0] len_q;
    logic          good_q, bad_q, dead_q, busy_q;

    logic [1:0]    eff_dir;
    logic [XW:0]   cand_x;
    logic [YW:0]   cand_y;
    logic          oob;
    logic          seg_match;
    logic          scan_last;
    logic          apple_hit;

    // Reversal onto the neck is not allowed: keep going the current way.
    assign eff_dir = (dir == (cur_dir ^ 2'b01)) ? cur_dir : dir;

    always_comb begin
        cand_x = {1'b0, hist_x[0]};
        cand_y = {1'b0, hist_y[0]};
        case (eff_dir)
            2'd0:    cand_x = {1'b0, hist_x[0]} + X_ONE;
            2'd1:    cand_x = {1'b0, hist_x[0]} - X_ONE;
            2'd2:    cand_y = {1'b0, hist_y[0]} - Y_ONE;
            default: cand_y = {1'b0, hist_y[0]} + Y_ONE;
        endcase
    end

    assign oob       = (nxt_x > X_MAX) || (nxt_y > Y_MAX);
    assign seg_match = (nxt_x[XW-1:0] == hist_x[scan_ptr]) &&
                       (nxt_y[YW-1:0] == hist_y[scan_ptr]);
    // Last body segment checked is snakeLen-2; the tail is about to vacate.
    assign scan_last = (LW'(scan_ptr) == (len_q - LW'(2)));
    assign apple_hit = (nxt_x == {1'b0, appleX}) && (nxt_y == {1'b0, appleY});

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (moveStrobe) state_d = S_CHECK;
            S_CHECK:  state_d = oob ? S_DEAD : S_SCAN;
            S_SCAN:   if (scan_last) state_d = S_COMMIT;
            S_COMMIT: state_d = hit_q ? S_DEAD : S_IDLE;
            S_DEAD:   state_d = S_DEAD;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst || restart) begin
            state_q  <= S_IDLE;
            cur_dir  <= 2'd0;
            len_q    <= LW'(INIT_LEN);
            nxt_x    <= '0;
            nxt_y    <= '0;
            scan_ptr <= '0;
            hit_q    <= 1'b0;
            good_q   <= 1'b0;
            bad_q    <= 1'b0;
            dead_q   <= 1'b0;
            busy_q   <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++) begin
                if (k < INIT_LEN) begin
                    hist_x[k] <= XW'(START_X - k);
                    hist_y[k] <= YW'(START_Y);
                end else begin
                    hist_x[k] <= '0;
                    hist_y[k] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            busy_q  <= (state_d == S_CHECK) || (state_d == S_SCAN) ||
                       (state_d == S_COMMIT);
            dead_q  <= (state_d == S_DEAD);
            case (state_q)
                S_IDLE: begin
                    if (moveStrobe) begin
                        nxt_x   <= cand_x;
                        nxt_y   <= cand_y;
                        cur_dir <= eff_dir;
                    end
                end
                S_CHECK: begin
                    scan_ptr <= '0;
                    hit_q    <= 1'b0;
                    if (oob) bad_q <= 1'b1;
                end
                S_SCAN: begin
                    hit_q    <= hit_q | seg_match;
                    scan_ptr <= scan_ptr + IW'(1);
                end
                S_COMMIT: begin
                    if (hit_q) begin
                        bad_q <= 1'b1;
                    end else begin
                        for (int k = MAX_LEN - 1; k > 0; k--) begin
                            hist_x[k] <= hist_x[k-1];
                            hist_y[k] <= hist_y[k-1];
                        end
                        hist_x[0] <= nxt_x[XW-1:0];
                        hist_y[0] <= nxt_y[YW-1:0];
                        if (apple_hit) begin
                            good_q <= 1'b1;
                            if (len_q != LW'(MAX_LEN)) len_q <= len_q + LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign goodColl  = good_q;
    assign badColl   = bad_q;
    assign isDead    = dead_q;
    assign busy      = busy_q;
    assign headX     = hist_x[0];
    assign headY     = hist_y[0];
    assign snakeLen  = len_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector
//   Directed bench for collision_detector: a table of move/restart records
//   with hand-computed results, plus hand-written sequences for dropped
//   strobes, back-to-back acceptance, aborts, border walks and length
//   saturation.
module tb_collision_detector;

    logic       tb_clk;
    logic       nRst;
    logic       moveStrobe;
    logic [1:0] dir;
    logic       restart;
    logic [3:0] appleX;
    logic [3:0] appleY;
    logic       goodColl;
    logic       badColl;
    logic       isDead;
    logic       busy;
    logic [3:0] headX;
    logic [3:0] headY;
    logic [5:0] snakeLen;
    logic [2:0] dbg_state;

    collision_detector #(
        .GRID_X(16), .GRID_Y(12), .MAX_LEN(32),
        .INIT_LEN(3), .START_X(4), .START_Y(6)
    ) dut (
        .clk(tb_clk), .nRst(nRst), .moveStrobe(moveStrobe), .dir(dir),
        .restart(restart), .appleX(appleX), .appleY(appleY),
        .goodColl(goodColl), .badColl(badColl), .isDead(isDead), .busy(busy),
        .headX(headX), .headY(headY), .snakeLen(snakeLen),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    typedef struct {
        int op;     // 0 = move, 1 = restart
        int d;
        int ax, ay;
        int ex, ey, elen;
        int egood, ebad, edead;
        int eacc;   // busy expected high right after the strobe edge
        int elat;   // edges after the strobe edge until busy is low
    } vec_t;

    vec_t vecs[$];
    logic [5:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int score    = 0;

    always @(negedge tb_clk) if (goodColl) score++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " headX"}, int'(headX), 4);
        check({tag, " headY"}, int'(headY), 6);
        check({tag, " len"}, int'(snakeLen), 3);
        check({tag, " flags"}, int'({goodColl, badColl, isDead, busy}), 0);
    endtask

    task automatic add_mv(input int d, ax, ay, ex, ey, elen,
                          input int egood, ebad, edead, eacc, elat);
        vec_t v;
        v.op = 0; v.d = d; v.ax = ax; v.ay = ay;
        v.ex = ex; v.ey = ey; v.elen = elen;
        v.egood = egood; v.ebad = ebad; v.edead = edead;
        v.eacc = eacc; v.elat = elat;
        vecs.push_back(v);
    endtask

    task automatic add_rs();
        vec_t v;
        v.op = 1; v.d = 0; v.ax = 0; v.ay = 0; v.ex = 4; v.ey = 6; v.elen = 3;
        v.egood = 0; v.ebad = 0; v.edead = 0; v.eacc = 0; v.elat = 0;
        vecs.push_back(v);
    endtask

    // driver tasks
    task automatic do_restart();
        @(negedge tb_clk);
        restart = 1'b1;
        @(posedge tb_clk);
        #1 restart = 1'b0;
    endtask

    task automatic strobe(input int d, input int ax, input int ay);
        @(negedge tb_clk);
        dir = 2'(d); appleX = 4'(ax); appleY = 4'(ay);
        moveStrobe = 1'b1;
        @(posedge tb_clk);
        #1 moveStrobe = 1'b0;
    endtask

    task automatic wait_idle(output int lat, output int goods, output int bads);
        lat = -1; goods = 0; bads = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge tb_clk);
            #1;
            goods += int'(goodColl);
            bads  += int'(badColl);
            if (!busy) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic apply_move(input vec_t v, input string tag);
        int lat, goods, bads, acc, extra;
        strobe(v.d, v.ax, v.ay);
        acc = int'(busy);
        wait_idle(lat, goods, bads);
        check({tag, " accepted"}, acc, v.eacc);
        check({tag, " latency"}, lat, v.elat);
        check({tag, " headX"}, int'(headX), v.ex);
        check({tag, " headY"}, int'(headY), v.ey);
        check({tag, " len"}, int'(snakeLen), v.elen);
        check({tag, " goodColl"}, goods, v.egood);
        check({tag, " badColl"}, bads, v.ebad);
        check({tag, " isDead"}, int'(isDead), v.edead);
        @(posedge tb_clk);
        #1 extra = int'(goodColl) + int'(badColl);
        check({tag, " pulse width"}, extra, 0);
    endtask

    initial begin
        int lat, goods, bads, s0;
        vec_t v;

        nRst = 1'b0; restart = 1'b0; moveStrobe = 1'b0;
        dir = 2'd0; appleX = 4'd0; appleY = 4'd0;

        // straight, apple, reversal, growth, self collision, dead
        add_mv(0, 10, 10, 5, 6, 3, 0, 0, 0, 1, 4);
        add_mv(0,  6,  6, 6, 6, 4, 1, 0, 0, 1, 4);
        add_mv(1, 10, 10, 7, 6, 4, 0, 0, 0, 1, 5);
        add_mv(0,  8,  6, 8, 6, 5, 1, 0, 0, 1, 5);
        add_mv(0,  9,  6, 9, 6, 6, 1, 0, 0, 1, 6);
        add_mv(2, 10, 10, 9, 5, 6, 0, 0, 0, 1, 7);
        add_mv(1, 10, 10, 8, 5, 6, 0, 0, 0, 1, 7);
        add_mv(3, 10, 10, 8, 5, 6, 0, 1, 1, 1, 7);
        add_mv(0, 10, 10, 8, 5, 6, 0, 0, 1, 0, 1);
        add_rs();
        // chase the tail around a 2x2 loop, growing onto the old tail cell
        add_mv(0, 5, 6, 5, 6, 4, 1, 0, 0, 1, 4);
        add_mv(2, 0, 0, 5, 5, 4, 0, 0, 0, 1, 5);
        add_mv(1, 0, 0, 4, 5, 4, 0, 0, 0, 1, 5);
        add_mv(3, 4, 6, 4, 6, 5, 1, 0, 0, 1, 5);
        add_rs();
        // top border
        for (int i = 1; i <= 6; i++) add_mv(2, 0, 0, 4, 6 - i, 3, 0, 0, 0, 1, 4);
        add_mv(2, 0, 0, 4, 0, 3, 0, 1, 1, 1, 1);
        add_mv(2, 0, 0, 4, 0, 3, 0, 0, 1, 0, 1);
        add_rs();
        // left border
        add_mv(2, 15, 11, 4, 5, 3, 0, 0, 0, 1, 4);
        for (int i = 1; i <= 4; i++) add_mv(1, 15, 11, 4 - i, 5, 3, 0, 0, 0, 1, 4);
        add_mv(1, 15, 11, 0, 5, 3, 0, 1, 1, 1, 1);
        add_rs();

        repeat (2) @(posedge tb_clk);
        #1 check_reset("reset");
        nRst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].op == 1) begin
                do_restart();
                check_reset($sformatf("v%0d restart", i));
            end else begin
                apply_move(vecs[i], $sformatf("v%0d", i));
            end
        end

        // four apples in a row, counted like a score keeper would
        s0 = score;
        for (int r = 0; r < 4; r++) begin
            do_restart();
            strobe(0, 6, 6);
            wait_idle(lat, goods, bads);
            strobe(0, 6, 6);
            wait_idle(lat, goods, bads);
            repeat (2) @(posedge tb_clk);
        end
        check("apple score", score - s0, 4);

        // right border
        do_restart();
        for (int i = 1; i <= 11; i++) begin
            v.op = 0; v.d = 0; v.ax = 0; v.ay = 0; v.ex = 4 + i; v.ey = 6;
            v.elen = 3; v.egood = 0; v.ebad = 0; v.edead = 0; v.eacc = 1; v.elat = 4;
            apply_move(v, $sformatf("right%0d", i));
        end
        v.ex = 15; v.ebad = 1; v.edead = 1; v.elat = 1;
        apply_move(v, "right edge");

        // bottom border
        do_restart();
        for (int i = 1; i <= 5; i++) begin
            v.op = 0; v.d = 3; v.ax = 0; v.ay = 0; v.ex = 4; v.ey = 6 + i;
            v.elen = 3; v.egood = 0; v.ebad = 0; v.edead = 0; v.eacc = 1; v.elat = 4;
            apply_move(v, $sformatf("down%0d", i));
        end
        v.ey = 11; v.ebad = 1; v.edead = 1; v.elat = 1;
        apply_move(v, "bottom edge");

        // strobe while busy is dropped
        do_restart();
        strobe(0, 0, 0);
        check("busy after strobe", int'(busy), 1);
        @(posedge tb_clk);
        strobe(2, 0, 0);
        wait_idle(lat, goods, bads);
        repeat (3) @(posedge tb_clk);
        #1;
        check("drop headX", int'(headX), 5);
        check("drop headY", int'(headY), 6);
        check("drop busy", int'(busy), 0);

        // strobe in the cycle busy falls is taken
        strobe(0, 0, 0);
        wait_idle(lat, goods, bads);
        moveStrobe = 1'b1; dir = 2'd0;
        @(posedge tb_clk);
        #1 moveStrobe = 1'b0;
        check("b2b accepted", int'(busy), 1);
        wait_idle(lat, goods, bads);
        check("b2b headX", int'(headX), 7);

        // restart in the middle of the body scan
        do_restart();
        strobe(0, 5, 6);
        @(posedge tb_clk);
        #1 restart = 1'b1;
        @(posedge tb_clk);
        #1 restart = 1'b0;
        check_reset("mid-scan restart");
        goods = 0; bads = 0;
        repeat (6) begin
            @(posedge tb_clk);
            #1;
            goods += int'(goodColl);
            bads  += int'(badColl);
        end
        check("abort pulses", goods + bads, 0);
        check("abort headX", int'(headX), 4);

        // nRst in the middle of a move
        strobe(0, 5, 6);
        @(posedge tb_clk);
        @(posedge tb_clk);
        #1 nRst = 1'b0;
        @(posedge tb_clk);
        #1 nRst = 1'b1;
        check_reset("mid-move nRst");

        // eat on every move up to and past the length ceiling
        do_restart();
        begin
            int x, y, len;
            x = 4; y = 6; len = 3;
            for (int i = 0; i < 31; i++) begin
                int d, nx, ny;
                if (i < 11) d = 0;
                else if (i == 11) d = 3;
                else if (i < 27) d = 1;
                else if (i == 27) d = 3;
                else d = 0;
                nx = x + ((d == 0) ? 1 : 0) - ((d == 1) ? 1 : 0);
                ny = y + ((d == 3) ? 1 : 0) - ((d == 2) ? 1 : 0);
                v.op = 0; v.d = d; v.ax = nx; v.ay = ny; v.ex = nx; v.ey = ny;
                v.elen = (len < 32) ? len + 1 : 32;
                v.egood = 1; v.ebad = 0; v.edead = 0; v.eacc = 1; v.elat = len + 1;
                exp_q.push_back(6'(v.elen));
                apply_move(v, $sformatf("grow%0d", i));
                check($sformatf("grow%0d sb len", i), int'(snakeLen), int'(exp_q.pop_front()));
                x = nx; y = ny; len = v.elen;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
